// File: rtl/spi_frame_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_slave
//  Brief    : SPI target (CPOL=0, selectable CPHA) oversampled by clk; commits
//             LSB-first write frames of exactly OUT_W bits, streams a readback word.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_frame_slave #(
   parameter int OUT_W       = 96,
   parameter int IN_W        = 96,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_sclk,
   input  logic             i_cs_n,
   input  logic             i_mosi,
   output logic             o_miso,
   output logic             o_miso_oe,
   output logic [OUT_W-1:0] o_data,
   output logic             o_valid,
   output logic             o_frame_err,
   input  logic [IN_W-1:0]  i_data,
   output logic             o_load,
   output logic             o_busy
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam int                c_cnt_w   = $clog2(OUT_W + 2);
   localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(OUT_W);
   localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(OUT_W + 1);

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_hist;
   logic                   r_cs_hist;

   state_t                 r_state;
   logic [OUT_W-1:0]       r_shadow;
   logic [IN_W-1:0]        r_tx_sr;
   logic [c_cnt_w-1:0]     r_cnt;
   logic                   r_first;

   logic                   w_sclk;
   logic                   w_cs_n;
   logic                   w_mosi;
   logic                   w_sclk_rise;
   logic                   w_sclk_fall;
   logic                   w_cs_fall;
   logic                   w_cs_rise;
   logic                   w_sample_edge;
   logic                   w_shift_edge;
   logic [OUT_W-1:0]       w_shadow_next;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk & ~r_sclk_hist;
   assign w_sclk_fall = ~w_sclk &  r_sclk_hist;
   assign w_cs_fall   = ~w_cs_n &  r_cs_hist;
   assign w_cs_rise   =  w_cs_n & ~r_cs_hist;

   assign w_sample_edge = (CPHA == 0) ? w_sclk_rise : w_sclk_fall;
   assign w_shift_edge  = (CPHA == 0) ? w_sclk_fall : w_sclk_rise;

   // Shift-right with the new bit entering at the MSB; legal for OUT_W == 1 too.
   assign w_shadow_next = OUT_W'({w_mosi, r_shadow} >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_hist <= 1'b0;
         r_cs_hist   <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
         r_sclk_hist <= w_sclk;
         r_cs_hist   <= w_cs_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_shadow    <= '0;
         r_tx_sr     <= '0;
         r_cnt       <= '0;
         r_first     <= 1'b0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_load      <= 1'b0;
      end else begin
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_load      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  r_state  <= ST_ACTIVE;
                  r_tx_sr  <= i_data;
                  o_load   <= 1'b1;
                  r_cnt    <= '0;
                  r_shadow <= '0;
                  r_first  <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               // SCLK activity coinciding with the CS rise is deliberately dropped.
               if (w_cs_rise) begin
                  r_state <= ST_IDLE;
                  if (r_cnt == c_cnt_full) begin
                     o_data  <= r_shadow;
                     o_valid <= 1'b1;
                  end else begin
                     o_frame_err <= 1'b1;
                  end
               end else begin
                  if (w_sample_edge) begin
                     r_shadow <= w_shadow_next;
                     if (r_cnt != c_cnt_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  if (w_shift_edge) begin
                     if ((CPHA == 1) && r_first) begin
                        r_first <= 1'b0;
                     end else begin
                        r_tx_sr <= r_tx_sr >> 1;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy    = (r_state == ST_ACTIVE);
   assign o_miso_oe = (r_state == ST_ACTIVE);
   assign o_miso    = (r_state == ST_ACTIVE) & r_tx_sr[0];

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_slave
//  Brief    : Randomised scoreboard bench for two spi_frame_slave configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_slave;

   typedef struct {
      logic         err;
      logic [127:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sclk  [2];
   logic         cs_n  [2];
   logic         mosi  [2];
   logic         miso  [2];
   logic         oe    [2];
   logic         valid [2];
   logic         err   [2];
   logic         load  [2];
   logic         busy  [2];
   logic [11:0]  data0;
   logic [7:0]   data1;
   logic [15:0]  rd0;
   logic [7:0]   rd1;

   int           checks   = 0;
   int           failures = 0;
   exp_t         q0[$];
   exp_t         q1[$];
   int           load_pend [2];
   logic [127:0] exp_data  [2];

   always #5 clk = ~clk;

   // dut0: 12-bit write, 16-bit readback, CPHA=0.  dut1: 8/8, CPHA=1.
   spi_frame_slave #(.OUT_W(12), .IN_W(16), .CPHA(0), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .i_sclk(sclk[0]), .i_cs_n(cs_n[0]), .i_mosi(mosi[0]),
      .o_miso(miso[0]), .o_miso_oe(oe[0]), .o_data(data0), .o_valid(valid[0]),
      .o_frame_err(err[0]), .i_data(rd0), .o_load(load[0]), .o_busy(busy[0]));

   spi_frame_slave #(.OUT_W(8), .IN_W(8), .CPHA(1), .SYNC_STAGES(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_sclk(sclk[1]), .i_cs_n(cs_n[1]), .i_mosi(mosi[1]),
      .o_miso(miso[1]), .o_miso_oe(oe[1]), .o_data(data1), .o_valid(valid[1]),
      .o_frame_err(err[1]), .i_data(rd1), .o_load(load[1]), .o_busy(busy[1]));

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Monitor: pops the scoreboard whenever a DUT raises a strobe.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [127:0] dv;
         exp_t         e;
         dv = (d == 0) ? 128'(data0) : 128'(data1);
         if (!rst_n) begin
            exp_data[d] = '0;
            chk("reset_outputs", {valid[d], err[d], load[d], busy[d], oe[d], miso[d]}, 0);
            chk("reset_data", dv, 0);
         end else begin
            if (load[d]) begin
               chk("load_expected", (load_pend[d] > 0), 1);
               if (load_pend[d] > 0) load_pend[d]--;
            end
            if (valid[d] || err[d]) begin
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  chk("unexpected_pulse", {valid[d], err[d]}, 0);
               end else begin
                  e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  chk("pulse_kind", {valid[d], err[d]}, e.err ? 2'b01 : 2'b10);
                  if (!e.err) begin
                     exp_data[d] = e.data;
                     chk("o_data_commit", dv, e.data);
                  end else begin
                     chk("o_data_hold_on_err", dv, exp_data[d]);
                  end
               end
            end else begin
               chk("o_data_stable", dv, exp_data[d]);
            end
            chk("oe_eq_busy", oe[d], busy[d]);
            if (!busy[d]) chk("miso_idle", miso[d], 0);
         end
      end
   end

   task automatic frame(input int d, input int nbits, input logic [127:0] w,
                        input logic [127:0] r, input int abort_at);
      int           ow, iw, half;
      logic [127:0] got, want;
      exp_t         e;
      ow   = (d == 0) ? 12 : 8;
      iw   = (d == 0) ? 16 : 8;
      half = $urandom_range(4, 6);
      got  = '0;
      want = '0;
      if (d == 0) rd0 = r[15:0];
      else        rd1 = r[7:0];
      step(2);
      cs_n[d] = 1'b0;
      load_pend[d]++;
      step(5);
      // Readback word must already be captured; changing it now must not matter.
      if (d == 0) rd0 = ~r[15:0];
      else        rd1 = ~r[7:0];
      chk("busy_in_frame", busy[d], 1);
      for (int i = 0; i < nbits; i++) begin
         if (d == 0) begin
            mosi[d] = w[i];
            step(half);
            got[i]  = miso[d];
            sclk[d] = 1'b1;
            step(half);
            sclk[d] = 1'b0;
         end else begin
            sclk[d] = 1'b1;
            mosi[d] = w[i];
            step(half);
            got[i]  = miso[d];
            sclk[d] = 1'b0;
            step(half);
         end
         if (i + 1 == abort_at) begin
            rst_n   = 1'b0;
            cs_n[d] = 1'b1;
            sclk[d] = 1'b0;
            load_pend[0] = 0;
            load_pend[1] = 0;
            step(4);
            rst_n = 1'b1;
            step(6);
            return;
         end
      end
      step(5);
      cs_n[d] = 1'b1;
      e.err  = (nbits != ow);
      e.data = w & ((128'd1 << ow) - 128'd1);
      push_exp(d, e);
      step(6);
      chk("busy_after_frame", busy[d], 0);
      for (int k = 0; k < nbits; k++) want[k] = (k < iw) ? r[k] : 1'b0;
      chk("miso_bits", got, want);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sclk[d] = 1'b0; cs_n[d] = 1'b1; mosi[d] = 1'b0;
         load_pend[d] = 0; exp_data[d] = '0;
      end
      rd0 = '0;
      rd1 = '0;
      step(4);
      rst_n = 1'b1;
      step(4);

      frame(0, 12, 128'hA5C, 128'hBEEF, -1);
      frame(0, 20, rnd128(), 128'hBEEF, -1);
      frame(0, 12, 128'h123, rnd128(), -1);
      frame(0, 11, rnd128(), rnd128(), -1);
      frame(0, 13, rnd128(), rnd128(), -1);
      frame(1, 8, 128'h3C, 128'hC3, -1);
      frame(0, 12, rnd128(), rnd128(), 6);
      frame(0, 12, 128'h0F0, rnd128(), -1);
      frame(0, 0, rnd128(), rnd128(), -1);
      frame(1, 0, rnd128(), rnd128(), -1);
      frame(1, 9, rnd128(), rnd128(), -1);

      for (int n = 0; n < 24; n++) begin
         int d, ow, nb;
         d  = int'($urandom_range(0, 1));
         ow = (d == 0) ? 12 : 8;
         nb = ($urandom_range(0, 9) < 7) ? ow : int'($urandom_range(0, ow + 3));
         frame(d, nb, rnd128(), rnd128(), -1);
      end

      step(20);
      chk("q0_drained", 128'(q0.size()), 0);
      chk("q1_drained", 128'(q1.size()), 0);
      chk("loads_seen0", 128'(load_pend[0]), 0);
      chk("loads_seen1", 128'(load_pend[1]), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
- Parametrised successor to the free-running ss-gated shift port.
- Real SPI target (CPOL=0, selectable CPHA) on an external SCLK. SCLK is oversampled by the system clock.
- Frames are received LSB-first into a shadow register. The shadow commits to a parallel output only on a correct-length frame.
- A parallel readback word is snapshotted at frame start and shifted out on MISO. One instance per SPI channel at the chip top; the core side sees only clean parallel words and strobes.

Parameters:
OUT_W, 96, bits per write frame; width of o_data (1..128)
IN_W, 96, width of readback word i_data (1..128)
CPHA, 0, 0: sample MOSI on SCLK rise, advance MISO on fall; 1: advance MISO on rise, sample on fall
SYNC_STAGES, 2, synchroniser depth for i_sclk/i_cs_n/i_mosi (2..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_sclk  in  1  SPI clock from host, asynchronous
i_cs_n  in  1  chip select, active low, asynchronous
i_mosi  in  1  host data
o_miso  out  1  target data
o_miso_oe  out  1  MISO output enable (1 while frame active)
o_data  out  OUT_W  last committed write word
o_valid  out  1  1-cycle pulse, o_data updated this cycle
o_frame_err  out  1  1-cycle pulse, frame ended with bit count != OUT_W
i_data  in  IN_W  readback word, sampled at frame start
o_load  out  1  1-cycle pulse in the cycle i_data is captured
o_busy  out  1  frame active (synchronised cs_n low)

Behaviour:
- Reset is decided: rst_n, asynchronous, active-low; clock clk. Reset values:
  - o_data=0; o_valid=o_frame_err=o_load=0; o_busy=0; o_miso=0; o_miso_oe=0.
  - Shadow, tx shift register, bit counter: 0.
  - Synchroniser flops: sclk=0, cs_n=1.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops, plus one history flop for sclk and cs_n.
  - Edge event = synced value differs from history.
  - Pin-to-event latency is SYNC_STAGES to SYNC_STAGES+1 clk.
  - Host requirement: SCLK high and low phases each >= SYNC_STAGES+2 clk. CS setup/hold to SCLK >= same.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on cs_n fall event. In that cycle:
  - tx_sr <= i_data and o_load=1.
  - bit counter <= 0; shadow <= 0; first-edge flag set.
- ACTIVE, sample edge (rise if CPHA=0, fall if CPHA=1):
  - shadow <= {mosi_sync, shadow[OUT_W-1:1]}.
  - Counter increments, saturating at OUT_W+1.
- ACTIVE, shift edge (fall if CPHA=0, rise if CPHA=1):
  - tx_sr <= {1'b0, tx_sr[IN_W-1:1]}.
  - For CPHA=1, the first rising edge of a frame does not shift (first-edge flag cleared instead). Bit 0 is therefore presented for the first sample.
- o_miso = tx_sr[0] while ACTIVE, 0 in IDLE. After IN_W bits, MISO outputs 0.
- ACTIVE -> IDLE on cs_n rise event:
  - Counter == OUT_W: o_data <= shadow, o_valid=1 in the same cycle o_data changes.
  - Otherwise: o_data holds, o_frame_err=1. This covers short, long and zero-length frames.
- o_busy = o_miso_oe = (state == ACTIVE).
- Simultaneous events:
  - A sclk edge in the same cycle as the cs_n rise event is ignored.
  - A sclk edge in the same cycle as the cs_n fall event is ignored (no shift, no sample).
- o_data is stable between o_valid pulses. The core may sample it any time.
- Reset mid-frame aborts the frame: no o_valid, no o_frame_err, o_data=0.
- i_data is not sampled outside the o_load cycle.

Test Plan:
- OUT_W=12, CPHA=0: send 12 bits LSB-first of 12'hA5C with SCLK period 8 clk -> single o_valid pulse, o_data=12'hA5C, no o_frame_err.
- IN_W=16, i_data=16'hBEEF at cs fall, i_data changed to 16'h0000 mid-frame -> MISO bits sampled by host on rises = 16'hBEEF LSB-first, o_load exactly one pulse. Bits 17+ read 0.
- Frame of 11 bits, then a frame of 13 bits, after o_data=12'h123 -> two o_frame_err pulses, o_data stays 12'h123, o_valid never asserted.
- CPHA=1, OUT_W=IN_W=8, write 8'h3C, i_data=8'hC3 -> o_data=8'h3C. Host sampling on falls reads 8'hC3; first rise does not shift.
- rst_n asserted after 6 of 12 bits, released, then a full frame of 12'h0F0 -> o_data=0 during/after reset with no pulses, then o_valid with o_data=12'h0F0.
- cs_n toggle low/high with no SCLK -> o_load pulse, then o_frame_err pulse; o_busy high only for the frame; o_miso_oe=0 in idle.
